// File: rtl/tri_pkg.sv
// Shared types and constants for the triangle vertex feeder.
package tri_pkg;

  localparam int unsigned CW        = 3;
  localparam int unsigned TRI_CNT_W = 16;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } vertex_t;

  typedef enum logic [2:0] {
    IDLE,
    V1,
    V2,
    V3,
    HOLD
  } state_e;

endpackage

// File: rtl/tri_vfifo.sv
// Vertex FIFO with first-word-fall-through head and a one-ahead peek.
module tri_vfifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  tri_pkg::vertex_t         din_i,
  input  logic                     pop_i,
  output tri_pkg::vertex_t         head_o,
  output tri_pkg::vertex_t         head1_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  import tri_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  vertex_t       mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

  // head1 is the entry behind the head; only meaningful when level >= 2
  assign head_o  = mem_q[rd_ptr_q];
  assign head1_o = mem_q[rd_ptr_q + AW'(1)];

  // Next pointer/occupancy; a push into a full FIFO is dropped even if a pop happens
  always_comb begin
    push_ok  = push_i && !full_o;
    pop_ok   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push_ok && !pop_ok) begin
      level_d = level_q + LW'(1);
    end else if (!push_ok && pop_ok) begin
      level_d = level_q - LW'(1);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/tri_vertex_feeder.sv
// Buffers host vertices and replays them as nt/xi/yi triangle loads to the engine.
module tri_vertex_feeder #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned CW       = tri_pkg::CW,
  parameter int unsigned HOLD_CYC = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CW-1:0]                 in_x,
  input  logic [CW-1:0]                 in_y,
  input  logic                          busy,
  output logic                          nt,
  output logic [CW-1:0]                 xi,
  output logic [CW-1:0]                 yi,
  output logic [$clog2(DEPTH):0]        level,
  output logic [tri_pkg::TRI_CNT_W-1:0] tri_cnt
);
  import tri_pkg::*;

  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam int unsigned HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  vertex_t                fifo_din;
  vertex_t                fifo_head;
  vertex_t                fifo_head1;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [LW-1:0]          fifo_level;
  logic                   pop;

  state_e                 state_q, state_d;
  logic                   nt_q, nt_d;
  logic [CW-1:0]          xi_q, xi_d;
  logic [CW-1:0]          yi_q, yi_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic [TRI_CNT_W-1:0]   tri_cnt_q, tri_cnt_d;

  assign fifo_din = '{x: in_x, y: in_y};

  tri_vfifo #(
    .DEPTH (DEPTH)
  ) u_vfifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (in_valid),
    .din_i   (fifo_din),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .head1_o (fifo_head1),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign in_ready = !fifo_full;
  assign level    = fifo_level;
  assign nt       = nt_q;
  assign xi       = xi_q;
  assign yi       = yi_q;
  assign tri_cnt  = tri_cnt_q;

  // Sequencer next-state and registered-output values.
  // Outputs are loaded one edge ahead: the vertex shown in Vn is captured at the
  // edge entering Vn, while the FIFO pop for it happens during Vn. So entering V1
  // takes the head, and entering V2/V3 takes the entry one behind the head.
  always_comb begin
    state_d   = state_q;
    nt_d      = 1'b0;
    xi_d      = '0;
    yi_d      = '0;
    hold_d    = hold_q;
    tri_cnt_d = tri_cnt_q;
    pop       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!busy && (fifo_level >= LW'(3))) begin
          state_d = V1;
          nt_d    = 1'b1;
          xi_d    = fifo_head.x;
          yi_d    = fifo_head.y;
        end
      end
      V1: begin
        pop     = !fifo_empty;
        state_d = V2;
        xi_d    = fifo_head1.x;
        yi_d    = fifo_head1.y;
      end
      V2: begin
        pop     = !fifo_empty;
        state_d = V3;
        xi_d    = fifo_head1.x;
        yi_d    = fifo_head1.y;
      end
      V3: begin
        pop       = !fifo_empty;
        state_d   = HOLD;
        hold_d    = '0;
        tri_cnt_d = tri_cnt_q + TRI_CNT_W'(1);
      end
      HOLD: begin
        if (busy || (hold_q == HW'(HOLD_CYC - 1))) begin
          state_d = IDLE;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer state, hold timer, triangle counter and engine-side outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      nt_q      <= 1'b0;
      xi_q      <= '0;
      yi_q      <= '0;
      hold_q    <= '0;
      tri_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      nt_q      <= nt_d;
      xi_q      <= xi_d;
      yi_q      <= yi_d;
      hold_q    <= hold_d;
      tri_cnt_q <= tri_cnt_d;
    end
  end

endmodule
